// File: rtl/hazard_pkg.sv
// Shared widths, stage-entry type and helpers for the P7 hazard controller.
package hazard_pkg;

  localparam int REG_W  = 5;
  localparam int TNEW_W = 3;
  localparam logic [TNEW_W-1:0] TUSE_NONE = 3'd7;

  typedef struct packed {
    logic [REG_W-1:0]  a3;
    logic [TNEW_W-1:0] tnew;
  } stageEntry_t;

  localparam stageEntry_t BUBBLE = '{a3: 5'd0, tnew: 3'd0};

  function automatic int selWidth(input int numStages);
    return $clog2(numStages + 1);
  endfunction

  function automatic logic [TNEW_W-1:0] tnewDec(input logic [TNEW_W-1:0] t);
    return (t == 3'd0) ? 3'd0 : t - 3'd1;
  endfunction

endpackage

// File: rtl/md_tracker.sv
// Mult/div unit tracker: start flag of the instruction in E and the busy countdown.
module md_tracker
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic captureEn,
  input  logic mdStart,
  input  logic mdDiv,
  output logic startE,
  output logic busy
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic             startE_r;
  logic             divE_r;
  logic [CNT_W-1:0] count_r;

  // E-stage md flags follow the pipeline; the counter ignores flush so an issued op still completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      startE_r <= 1'b0;
      divE_r   <= 1'b0;
      count_r  <= '0;
    end else begin
      if (!flush && captureEn) begin
        startE_r <= mdStart;
        divE_r   <= mdDiv;
      end else begin
        startE_r <= 1'b0;
        divE_r   <= 1'b0;
      end
      if (startE_r) begin
        count_r <= divE_r ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
      end else if (count_r != '0) begin
        count_r <= count_r - CNT_W'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign startE = startE_r;
  assign busy   = (count_r != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall and forward-select generation for the P7 pipeline from tracked in-flight producers.
// Define HAZ_MD_EN to include the mult/div busy tracker and its D-stage stall term.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int  NUM_STAGES = 3,
  parameter int  NUM_SRC    = 2,
  parameter int  MUL_CYCLES = 5,
  parameter int  DIV_CYCLES = 10,
  localparam int SEL_W      = selWidth(NUM_STAGES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      d_valid,
  input  logic [REG_W*NUM_SRC-1:0]  d_src,
  input  logic [TNEW_W*NUM_SRC-1:0] d_tuse,
  input  logic [REG_W-1:0]          d_a3,
  input  logic [TNEW_W-1:0]         d_tnew,
  input  logic                      d_md_use,
  input  logic                      d_md_start,
  input  logic                      d_md_div,
  output logic                      stall,
  output logic [SEL_W*NUM_SRC-1:0]  fwd_d_sel,
  output logic [SEL_W*NUM_SRC-1:0]  fwd_e_sel,
  output logic                      md_start_e,
  output logic                      md_busy
);

  stageEntry_t       stg_r [1:NUM_STAGES];
  logic [REG_W-1:0]  eSrc_r [NUM_SRC];

  logic              depStall_s;
  logic              mdStall_s;
  logic              capture_s;
  logic [REG_W-1:0]  dSrc_s;
  logic              dMatch_s, eMatch_s;
  logic              dHit_s, eHit_s;
  logic [SEL_W-1:0]  dK_s, eK_s;
  logic [TNEW_W-1:0] dTnew_s, eTnew_s;

  // Nearest-producer search per source, then stall and forward selects.
  always_comb begin
    depStall_s = 1'b0;
    fwd_d_sel  = '0;
    fwd_e_sel  = '0;
    dSrc_s     = '0;
    dMatch_s   = 1'b0;
    eMatch_s   = 1'b0;
    dHit_s     = 1'b0;
    eHit_s     = 1'b0;
    dK_s       = '0;
    eK_s       = '0;
    dTnew_s    = '0;
    eTnew_s    = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      dSrc_s  = d_src[REG_W*s +: REG_W];
      dHit_s  = 1'b0;
      eHit_s  = 1'b0;
      dK_s    = '0;
      eK_s    = '0;
      dTnew_s = '0;
      eTnew_s = '0;
      // Walk oldest to newest so the youngest matching producer is what remains.
      for (int k = NUM_STAGES; k >= 1; k--) begin
        dMatch_s = (dSrc_s != 5'd0) && (dSrc_s == stg_r[k].a3);
        eMatch_s = (k >= 2) && (eSrc_r[s] != 5'd0) && (eSrc_r[s] == stg_r[k].a3);
        dHit_s   = dHit_s | dMatch_s;
        dK_s     = dMatch_s ? SEL_W'(k) : dK_s;
        dTnew_s  = dMatch_s ? stg_r[k].tnew : dTnew_s;
        eHit_s   = eHit_s | eMatch_s;
        eK_s     = eMatch_s ? SEL_W'(k) : eK_s;
        eTnew_s  = eMatch_s ? stg_r[k].tnew : eTnew_s;
      end
      depStall_s = depStall_s | (dHit_s && (d_tuse[TNEW_W*s +: TNEW_W] < dTnew_s));
      fwd_d_sel[SEL_W*s +: SEL_W] = (dHit_s && (dTnew_s == 3'd0)) ? dK_s : '0;
      fwd_e_sel[SEL_W*s +: SEL_W] = (eHit_s && (eTnew_s == 3'd0)) ? eK_s : '0;
    end
    stall = d_valid && (depStall_s || mdStall_s);
  end

  assign capture_s = d_valid && !stall;

  // Producer shift register: D enters stage 1, older entries age toward W.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int k = 1; k <= NUM_STAGES; k++) begin
        stg_r[k] <= BUBBLE;
      end
      for (int s = 0; s < NUM_SRC; s++) begin
        eSrc_r[s] <= 5'd0;
      end
    end else begin
      for (int k = 2; k <= NUM_STAGES; k++) begin
        stg_r[k] <= '{a3: stg_r[k-1].a3, tnew: tnewDec(stg_r[k-1].tnew)};
      end
      if (capture_s) begin
        stg_r[1] <= '{a3: d_a3, tnew: d_tnew};
        for (int s = 0; s < NUM_SRC; s++) begin
          eSrc_r[s] <= d_src[REG_W*s +: REG_W];
        end
      end else begin
        stg_r[1] <= BUBBLE;
        for (int s = 0; s < NUM_SRC; s++) begin
          eSrc_r[s] <= 5'd0;
        end
      end
    end
  end

`ifdef HAZ_MD_EN
  md_tracker #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_mdTracker (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .captureEn(capture_s),
    .mdStart  (d_md_start),
    .mdDiv    (d_md_div),
    .startE   (md_start_e),
    .busy     (md_busy)
  );

  assign mdStall_s = d_md_use && (md_start_e || md_busy);
`else
  logic unusedMd_s;

  assign unusedMd_s = ^{d_md_use, d_md_start, d_md_div};
  assign md_start_e = 1'b0;
  assign md_busy    = 1'b0;
  assign mdStall_s  = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a reference pipeline model predicts every cycle's outputs.
module tb_hazard_ctrl;

  localparam int N    = 3;
  localparam int S    = 2;
  localparam int MULC = 5;
  localparam int DIVC = 10;
`ifdef HAZ_MD_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, flush, d_valid;
  logic [9:0] d_src;
  logic [5:0] d_tuse;
  logic [4:0] d_a3;
  logic [2:0] d_tnew;
  logic       d_md_use, d_md_start, d_md_div;
  logic       stall;
  logic [3:0] fwd_d_sel, fwd_e_sel;
  logic       md_start_e, md_busy;

  hazard_ctrl #(
    .NUM_STAGES(N),
    .NUM_SRC   (S),
    .MUL_CYCLES(MULC),
    .DIV_CYCLES(DIVC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .d_valid   (d_valid),
    .d_src     (d_src),
    .d_tuse    (d_tuse),
    .d_a3      (d_a3),
    .d_tnew    (d_tnew),
    .d_md_use  (d_md_use),
    .d_md_start(d_md_start),
    .d_md_div  (d_md_div),
    .stall     (stall),
    .fwd_d_sel (fwd_d_sel),
    .fwd_e_sel (fwd_e_sel),
    .md_start_e(md_start_e),
    .md_busy   (md_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       stall;
    logic [3:0] fd;
    logic [3:0] fe;
    logic       ms;
    logic       mb;
  } exp_t;

  exp_t sbQ[$];

  int numCompared   = 0;
  int numMismatched = 0;

  // Reference model: producers stored with their Tnew at E entry; age gives the current Tnew.
  logic [4:0] mA3 [1:N];
  logic [2:0] mT0 [1:N];
  logic [4:0] mESrc [S];
  logic       mEMd, mEDiv;
  int         busyUntil = -1;
  int         cyc = 0;

  logic       lastStall, lastMs, lastMb;
  logic [3:0] lastFd, lastFe;
  int         nSt;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] want);
    numCompared++;
    if (got !== want) begin
      numMismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [2:0] tnewAt(input logic [2:0] t0, input int age);
    if (int'(t0) > age) return 3'(int'(t0) - age);
    return 3'd0;
  endfunction

  task automatic clearModel();
    for (int k = 1; k <= N; k++) begin
      mA3[k] = 5'd0;
      mT0[k] = 3'd0;
    end
    for (int s = 0; s < S; s++) mESrc[s] = 5'd0;
    mEMd  = 1'b0;
    mEDiv = 1'b0;
  endtask

  task automatic setD(input logic v, input logic [4:0] a3, input logic [2:0] tn,
                      input logic [4:0] s0, input logic [2:0] u0,
                      input logic [4:0] s1, input logic [2:0] u1,
                      input logic mu, input logic ms, input logic md);
    d_valid = v; d_a3 = a3; d_tnew = tn;
    d_src = {s1, s0}; d_tuse = {u1, u0};
    d_md_use = mu; d_md_start = ms; d_md_div = md;
  endtask

  task automatic idleD();
    setD(1'b0, 5'd0, 3'd0, 5'd0, 3'd7, 5'd0, 3'd7, 1'b0, 1'b0, 1'b0);
  endtask

  // One clock: predict, push, sample at negedge, pop/compare, then advance the model at posedge.
  task automatic runCycle(input bit rst, input bit fl, input bit doCheck);
    exp_t       e;
    logic [4:0] src;
    logic [2:0] tk;
    logic       dep;
    bit         found;
    reset = rst;
    flush = fl;
    e   = '0;
    dep = 1'b0;
    for (int s = 0; s < S; s++) begin
      src   = d_src[5*s +: 5];
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        if (!found && src != 5'd0 && mA3[k] == src) begin
          found = 1'b1;
          tk    = tnewAt(mT0[k], k - 1);
          dep   = dep | (d_tuse[3*s +: 3] < tk);
          if (tk == 3'd0) e.fd[2*s +: 2] = 2'(k);
        end
      end
      found = 1'b0;
      for (int k = 2; k <= N; k++) begin
        if (!found && mESrc[s] != 5'd0 && mA3[k] == mESrc[s]) begin
          found = 1'b1;
          tk    = tnewAt(mT0[k], k - 1);
          if (tk == 3'd0) e.fe[2*s +: 2] = 2'(k);
        end
      end
    end
    e.ms    = MD_EN & mEMd;
    e.mb    = MD_EN && (cyc <= busyUntil);
    e.stall = d_valid && (dep || (MD_EN && d_md_use && (e.ms || e.mb)));
    sbQ.push_back(e);

    @(negedge clk);
    e = sbQ.pop_front();
    lastStall = stall; lastFd = fwd_d_sel; lastFe = fwd_e_sel;
    lastMs = md_start_e; lastMb = md_busy;
    if (doCheck) begin
      checkEq($sformatf("stall@%0d", cyc), 32'(stall), 32'(e.stall));
      checkEq($sformatf("fwdD@%0d", cyc), 32'(fwd_d_sel), 32'(e.fd));
      checkEq($sformatf("fwdE@%0d", cyc), 32'(fwd_e_sel), 32'(e.fe));
      checkEq($sformatf("mdStartE@%0d", cyc), 32'(md_start_e), 32'(e.ms));
      checkEq($sformatf("mdBusy@%0d", cyc), 32'(md_busy), 32'(e.mb));
    end

    @(posedge clk);
    if (rst) busyUntil = -1;
    else if (mEMd) busyUntil = cyc + (mEDiv ? DIVC : MULC);
    if (rst || fl) begin
      clearModel();
    end else begin
      for (int k = N; k >= 2; k--) begin
        mA3[k] = mA3[k-1];
        mT0[k] = mT0[k-1];
      end
      if (d_valid && !e.stall) begin
        mA3[1] = d_a3; mT0[1] = d_tnew;
        for (int s = 0; s < S; s++) mESrc[s] = d_src[5*s +: 5];
        mEMd = d_md_start; mEDiv = d_md_div;
      end else begin
        mA3[1] = 5'd0; mT0[1] = 3'd0;
        for (int s = 0; s < S; s++) mESrc[s] = 5'd0;
        mEMd = 1'b0; mEDiv = 1'b0;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) runCycle(1'b0, 1'b0, 1'b1);
  endtask

  // Present an instruction in D, holding it while the DUT stalls; returns the stall count.
  task automatic issue(input logic [4:0] a3, input logic [2:0] tn,
                       input logic [4:0] s0, input logic [2:0] u0,
                       input logic [4:0] s1, input logic [2:0] u1,
                       input logic mu, input logic ms, input logic md, output int nStall);
    nStall = 0;
    setD(1'b1, a3, tn, s0, u0, s1, u1, mu, ms, md);
    for (int i = 0; i < 20; i++) begin
      runCycle(1'b0, 1'b0, 1'b1);
      if (!lastStall) break;
      nStall++;
    end
    if (nStall >= 20) checkEq("issueTimeout", 32'(nStall), 32'd0);
    idleD();
  endtask

  initial begin
    clearModel();
    reset = 1'b1;
    flush = 1'b0;
    idleD();
    @(posedge clk);
    #1;

    // Reset state, with a reader present in D.
    setD(1'b1, 5'd3, 3'd1, 5'd1, 3'd0, 5'd2, 3'd0, 1'b1, 1'b0, 1'b0);
    runCycle(1'b1, 1'b0, 1'b1);
    runCycle(1'b1, 1'b0, 1'b1);
    idleD();
    idles(2);

    // lw $1 then beq $1: two stalls then forward from W.
    issue(5'd1, 3'd2, 5'd0, 3'd7, 5'd0, 3'd7, 1'b0, 1'b0, 1'b0, nSt);
    issue(5'd0, 3'd0, 5'd1, 3'd0, 5'd0, 3'd7, 1'b0, 1'b0, 1'b0, nSt);
    checkEq("lwBeqStalls", 32'(nSt), 32'd2);
    checkEq("lwBeqFwdD", 32'(lastFd[1:0]), 32'd3);
    idles(3);

    // addu $2 then addu $3,$2: no stall, E forward from M next cycle.
    issue(5'd2, 3'd1, 5'd0, 3'd7, 5'd0, 3'd7, 1'b0, 1'b0, 1'b0, nSt);
    issue(5'd3, 3'd1, 5'd2, 3'd1, 5'd0, 3'd7, 1'b0, 1'b0, 1'b0, nSt);
    checkEq("adduStalls", 32'(nSt), 32'd0);
    idles(1);
    checkEq("adduFwdE", 32'(lastFe[1:0]), 32'd2);
    idles(3);

    // $5 written twice: the newer producer always wins.
    issue(5'd5, 3'd1, 5'd0, 3'd7, 5'd0, 3'd7, 1'b0, 1'b0, 1'b0, nSt);
    issue(5'd5, 3'd1, 5'd0, 3'd7, 5'd0, 3'd7, 1'b0, 1'b0, 1'b0, nSt);
    issue(5'd6, 3'd1, 5'd5, 3'd1, 5'd0, 3'd7, 1'b0, 1'b0, 1'b0, nSt);
    checkEq("dup5FwdDNotOld", 32'(lastFd[1:0]), 32'd0);
    idles(1);
    checkEq("dup5FwdE", 32'(lastFe[1:0]), 32'd2);
    idles(3);
    issue(5'd5, 3'd1, 5'd0, 3'd7, 5'd0, 3'd7, 1'b0, 1'b0, 1'b0, nSt);
    issue(5'd5, 3'd1, 5'd0, 3'd7, 5'd0, 3'd7, 1'b0, 1'b0, 1'b0, nSt);
    idles(1);
    issue(5'd6, 3'd1, 5'd0, 3'd7, 5'd5, 3'd1, 1'b0, 1'b0, 1'b0, nSt);
    checkEq("dup5FwdDM", 32'(lastFd[3:2]), 32'd2);
    idles(3);

    // mult then mfhi, div then mfhi.
    issue(5'd0, 3'd0, 5'd1, 3'd0, 5'd2, 3'd0, 1'b1, 1'b1, 1'b0, nSt);
    issue(5'd8, 3'd1, 5'd0, 3'd7, 5'd0, 3'd7, 1'b1, 1'b0, 1'b0, nSt);
    checkEq("multMfhiStalls", 32'(nSt), MD_EN ? 32'd6 : 32'd0);
    idles(12);
    issue(5'd0, 3'd0, 5'd1, 3'd0, 5'd2, 3'd0, 1'b1, 1'b1, 1'b1, nSt);
    issue(5'd8, 3'd1, 5'd0, 3'd7, 5'd0, 3'd7, 1'b1, 1'b0, 1'b0, nSt);
    checkEq("divMfhiStalls", 32'(nSt), MD_EN ? 32'd11 : 32'd0);
    idles(12);

    // Flush while lw $4 sits in E and its reader stalls in D.
    issue(5'd4, 3'd2, 5'd0, 3'd7, 5'd0, 3'd7, 1'b0, 1'b0, 1'b0, nSt);
    setD(1'b1, 5'd7, 3'd1, 5'd4, 3'd0, 5'd0, 3'd7, 1'b0, 1'b0, 1'b0);
    runCycle(1'b0, 1'b1, 1'b1);
    checkEq("flushCycleStall", 32'(lastStall), 32'd1);
    runCycle(1'b0, 1'b0, 1'b1);
    checkEq("postFlushStall", 32'(lastStall), 32'd0);
    checkEq("postFlushFwd", 32'(lastFd), 32'd0);
    idleD();
    idles(3);

    // Register $0 never creates a dependence.
    issue(5'd0, 3'd2, 5'd0, 3'd7, 5'd0, 3'd7, 1'b0, 1'b0, 1'b0, nSt);
    issue(5'd9, 3'd1, 5'd0, 3'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, nSt);
    checkEq("zeroSrcStalls", 32'(nSt), 32'd0);
    checkEq("zeroSrcFwd", 32'(lastFd), 32'd0);
    idles(3);

    // Reset in the middle of a divide.
    issue(5'd0, 3'd0, 5'd1, 3'd0, 5'd2, 3'd0, 1'b1, 1'b1, 1'b1, nSt);
    idles(3);
    checkEq("divBusyBeforeReset", 32'(lastMb), MD_EN ? 32'd1 : 32'd0);
    runCycle(1'b1, 1'b0, 1'b1);
    runCycle(1'b0, 1'b0, 1'b1);
    checkEq("divBusyAfterReset", 32'(lastMb), 32'd0);

    // Random traffic over a small register set to provoke collisions.
    for (int i = 0; i < 300; i++) begin
      setD(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 3) ? 3'd7 : 3'($urandom_range(0, 2)),
           5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 3) ? 3'd7 : 3'($urandom_range(0, 2)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      runCycle(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 15) == 0), 1'b1);
    end

    checkEq("sbEmpty", 32'(sbQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
